// File: rtl/order_dispatch_ctrl_if.sv
// Command, engine and status bundle for order_dispatch_ctrl.
// slave: the dispatcher side; master: feed decoder / engines / observers.
interface order_dispatch_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_price;
    logic [7:0]  cmd_qty;
    logic [1:0]  eng_start;
    logic [15:0] eng_price;
    logic [7:0]  eng_qty;
    logic [1:0]  eng_done;
    logic [15:0] eng_best_price;
    logic [8:0]  book_size;
    logic [15:0] best_price;
    logic        price_valid;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] stat_add;
    logic [15:0] stat_cxl;
    logic [15:0] stat_rej;

    modport slave (
        input  cmd_valid, cmd_op, cmd_price, cmd_qty, eng_done, eng_best_price,
        output cmd_ready, eng_start, eng_price, eng_qty, book_size, best_price,
               price_valid, err, err_code, stat_add, stat_cxl, stat_rej
    );

    modport master (
        output cmd_valid, cmd_op, cmd_price, cmd_qty, eng_done, eng_best_price,
        input  cmd_ready, eng_start, eng_price, eng_qty, book_size, best_price,
               price_valid, err, err_code, stat_add, stat_cxl, stat_rej
    );
endinterface

// File: rtl/order_dispatch_ctrl.sv
// Order command sequencer: screens against book occupancy, dispatches to add/cancel engines,
// times out silent engines. Optional statistics counters under DISPATCH_STATS_EN.
module order_dispatch_ctrl #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    order_dispatch_ctrl_if.slave bus
);
    localparam logic [8:0] L_DEPTH    = 9'(DEPTH);
    localparam logic [7:0] L_WAIT_MAX = 8'(TIMEOUT - 1);

    typedef enum logic {StIdle, StWait} state_e;
    typedef enum logic [1:0] {ErrFull, ErrEmpty, ErrBadOp, ErrTimeout} err_e;

    state_e      r_state;
    logic        r_cmd_ready;
    logic        r_op_cxl;
    logic [7:0]  r_wait_cnt;
    logic [1:0]  r_eng_start;
    logic [15:0] r_eng_price;
    logic [7:0]  r_eng_qty;
    logic [8:0]  r_book_size;
    logic [15:0] r_best_price;
    logic        r_price_valid;
    logic        r_err;
    logic [1:0]  r_err_code;

    logic        w_accept;
    logic        w_rej;
    logic [1:0]  w_rej_code;
    logic [1:0]  w_start;
    logic        w_add_done;
    logic        w_cxl_done;
    logic        w_timeout;
    logic [8:0]  w_size_dec;

    always_comb begin
        w_rej      = 1'b0;
        w_rej_code = ErrFull;
        w_start    = 2'b00;
        case (bus.cmd_op)
            2'd0: begin
                if (r_book_size == L_DEPTH) begin
                    w_rej      = 1'b1;
                    w_rej_code = ErrFull;
                end else begin
                    w_start = 2'b01;
                end
            end
            2'd1: begin
                if (r_book_size == 9'd0) begin
                    w_rej      = 1'b1;
                    w_rej_code = ErrEmpty;
                end else begin
                    w_start = 2'b10;
                end
            end
            default: begin
                w_rej      = 1'b1;
                w_rej_code = ErrBadOp;
            end
        endcase
    end

    assign w_accept   = (r_state == StIdle) && bus.cmd_valid && r_cmd_ready;
    // Only the dispatched engine's done bit counts; the other bit is a stray.
    assign w_add_done = (r_state == StWait) && !r_op_cxl && bus.eng_done[0];
    assign w_cxl_done = (r_state == StWait) && r_op_cxl && bus.eng_done[1];
    assign w_timeout  = (r_state == StWait) && !w_add_done && !w_cxl_done
                        && (r_wait_cnt == L_WAIT_MAX);
    assign w_size_dec = r_book_size - 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cmd_ready   <= 1'b1;
            r_op_cxl      <= 1'b0;
            r_wait_cnt    <= 8'd0;
            r_eng_start   <= 2'b00;
            r_eng_price   <= 16'd0;
            r_eng_qty     <= 8'd0;
            r_book_size   <= 9'd0;
            r_best_price  <= 16'd0;
            r_price_valid <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= 2'd0;
        end else begin
            r_eng_start <= 2'b00;
            r_err       <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_eng_price <= bus.cmd_price;
                        r_eng_qty   <= bus.cmd_qty;
                        if (w_rej) begin
                            r_err      <= 1'b1;
                            r_err_code <= w_rej_code;
                        end else begin
                            r_eng_start <= w_start;
                            r_op_cxl    <= w_start[1];
                            r_wait_cnt  <= 8'd0;
                            r_cmd_ready <= 1'b0;
                            r_state     <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (w_add_done) begin
                        r_book_size   <= r_book_size + 9'd1;
                        r_best_price  <= bus.eng_best_price;
                        r_price_valid <= 1'b1;
                        r_cmd_ready   <= 1'b1;
                        r_state       <= StIdle;
                    end else if (w_cxl_done) begin
                        r_book_size <= w_size_dec;
                        if (w_size_dec == 9'd0) begin
                            r_best_price  <= 16'd0;
                            r_price_valid <= 1'b0;
                        end else begin
                            r_best_price <= bus.eng_best_price;
                        end
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_err_code  <= ErrTimeout;
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [15:0] r_stat_add;
    logic [15:0] r_stat_cxl;
    logic [15:0] r_stat_rej;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_add <= 16'd0;
            r_stat_cxl <= 16'd0;
            r_stat_rej <= 16'd0;
        end else begin
            if (w_add_done && (r_stat_add != 16'hFFFF)) r_stat_add <= r_stat_add + 16'd1;
            if (w_cxl_done && (r_stat_cxl != 16'hFFFF)) r_stat_cxl <= r_stat_cxl + 16'd1;
            if (((w_accept && w_rej) || w_timeout) && (r_stat_rej != 16'hFFFF)) begin
                r_stat_rej <= r_stat_rej + 16'd1;
            end
        end
    end

    assign bus.stat_add = r_stat_add;
    assign bus.stat_cxl = r_stat_cxl;
    assign bus.stat_rej = r_stat_rej;
`else
    assign bus.stat_add = 16'd0;
    assign bus.stat_cxl = 16'd0;
    assign bus.stat_rej = 16'd0;
`endif

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.eng_start   = r_eng_start;
    assign bus.eng_price   = r_eng_price;
    assign bus.eng_qty     = r_eng_qty;
    assign bus.book_size   = r_book_size;
    assign bus.best_price  = r_best_price;
    assign bus.price_valid = r_price_valid;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;
endmodule

// File: tb/tb_order_dispatch_ctrl.sv
// Randomized bench for order_dispatch_ctrl against a transaction-level book model.
module tb_order_dispatch_ctrl;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    order_dispatch_ctrl_if bus();

    order_dispatch_ctrl #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference book state
    int          m_size;
    logic [15:0] m_best;
    logic        m_valid;
    int          m_add;
    int          m_cxl;
    int          m_rej;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_size  = 0;
        m_best  = 16'd0;
        m_valid = 1'b0;
        m_add   = 0;
        m_cxl   = 0;
        m_rej   = 0;
    endtask

    task automatic check_book(input string tag);
        int e_add, e_cxl, e_rej;
`ifdef DISPATCH_STATS_EN
        e_add = sat(m_add);
        e_cxl = sat(m_cxl);
        e_rej = sat(m_rej);
`else
        e_add = 0;
        e_cxl = 0;
        e_rej = 0;
`endif
        check_val({tag, ".size"}, 32'(bus.book_size), 32'(m_size));
        check_val({tag, ".best"}, 32'(bus.best_price), 32'(m_best));
        check_val({tag, ".pvalid"}, 32'(bus.price_valid), 32'(m_valid));
        check_val({tag, ".stat_add"}, 32'(bus.stat_add), 32'(e_add));
        check_val({tag, ".stat_cxl"}, 32'(bus.stat_cxl), 32'(e_cxl));
        check_val({tag, ".stat_rej"}, 32'(bus.stat_rej), 32'(e_rej));
    endtask

    // done_at: wait cycle carrying the matching done (0 or >TIMEOUT = silent engine).
    // stray_at: wait cycle carrying the other engine's done (0 = none).
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] price, input logic [7:0] qty,
                          input int done_at, input int stray_at, input logic [15:0] best);
        int          rej_code;
        logic [1:0]  match;
        logic [1:0]  done;
        check_val("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_price = price;
        bus.cmd_qty   = qty;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        check_val("eng_price", 32'(bus.eng_price), 32'(price));
        check_val("eng_qty", 32'(bus.eng_qty), 32'(qty));

        rej_code = -1;
        if (op >= 2'd2) rej_code = 2;
        else if (op == 2'd0 && m_size == int'(DEPTH)) rej_code = 0;
        else if (op == 2'd1 && m_size == 0) rej_code = 1;

        if (rej_code >= 0) begin
            m_rej++;
            check_val("rej_err", 32'(bus.err), 32'd1);
            check_val("rej_code", 32'(bus.err_code), 32'(rej_code));
            check_val("rej_start", 32'(bus.eng_start), 32'd0);
            check_val("rej_ready", 32'(bus.cmd_ready), 32'd1);
            check_book("rej");
            step();
            check_val("rej_err_pulse", 32'(bus.err), 32'd0);
            return;
        end

        match = (op == 2'd0) ? 2'b01 : 2'b10;
        check_val("disp_start", 32'(bus.eng_start), 32'(match));
        check_val("disp_ready", 32'(bus.cmd_ready), 32'd0);
        check_val("disp_err", 32'(bus.err), 32'd0);

        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            done = 2'b00;
            if (k == done_at) done = done | match;
            if (k == stray_at) done = done | ~match;
            bus.eng_done       = done;
            bus.eng_best_price = (k == done_at) ? best : 16'($urandom);
            step();
            bus.eng_done = 2'b00;
            if (k == done_at) begin
                if (op == 2'd0) begin
                    m_size++;
                    m_best  = best;
                    m_valid = 1'b1;
                    m_add++;
                end else begin
                    m_size--;
                    m_best  = (m_size == 0) ? 16'd0 : best;
                    m_valid = (m_size != 0);
                    m_cxl++;
                end
                check_val("done_err", 32'(bus.err), 32'd0);
                check_val("done_ready", 32'(bus.cmd_ready), 32'd1);
                check_book("done");
                return;
            end
            if (k == int'(TIMEOUT)) begin
                m_rej++;
                check_val("tmo_err", 32'(bus.err), 32'd1);
                check_val("tmo_code", 32'(bus.err_code), 32'd3);
                check_val("tmo_ready", 32'(bus.cmd_ready), 32'd1);
                check_book("tmo");
                return;
            end
            check_val("wait_ready", 32'(bus.cmd_ready), 32'd0);
            check_val("wait_start", 32'(bus.eng_start), 32'd0);
            check_val("wait_err", 32'(bus.err), 32'd0);
        end
    endtask

    initial begin
        bus.cmd_valid      = 1'b0;
        bus.cmd_op         = 2'd0;
        bus.cmd_price      = 16'd0;
        bus.cmd_qty        = 8'd0;
        bus.eng_done       = 2'b00;
        bus.eng_best_price = 16'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check_val("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("rst_start", 32'(bus.eng_start), 32'd0);
        check_val("rst_price", 32'(bus.eng_price), 32'd0);
        check_val("rst_qty", 32'(bus.eng_qty), 32'd0);
        check_val("rst_err", 32'(bus.err), 32'd0);
        check_val("rst_code", 32'(bus.err_code), 32'd0);
        check_book("rst");

        // Directed scenarios
        do_cmd(2'd1, 16'h0200, 8'd1, 2, 0, 16'h0);        // cancel on empty book
        do_cmd(2'd0, 16'h0100, 8'd5, 3, 0, 16'h0100);     // basic add
        do_cmd(2'd1, 16'h0100, 8'd5, 2, 0, 16'h1234);     // cancel to empty
        for (int i = 0; i < 4; i++) do_cmd(2'd0, 16'(16'h0300 + i), 8'd1, 2, 0, 16'(16'h0300 + i));
        do_cmd(2'd0, 16'h0400, 8'd2, 2, 0, 16'h0400);     // full
        do_cmd(2'd1, 16'h0300, 8'd1, 0, 0, 16'h0);        // silent engine
        do_cmd(2'd1, 16'h0300, 8'd1, int'(TIMEOUT), 0, 16'h0301); // done in last wait cycle
        do_cmd(2'd0, 16'h0500, 8'd3, 4, 2, 16'h0500);     // stray cancel done first
        do_cmd(2'd3, 16'h0600, 8'd3, 2, 0, 16'h0);        // bad op

        // Done while idle must be ignored
        bus.eng_done       = 2'b11;
        bus.eng_best_price = 16'hBEEF;
        step();
        bus.eng_done = 2'b00;
        step();
        check_book("idle_done");

        for (int n = 0; n < 300; n++) begin
            int          sel;
            logic [1:0]  op;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) op = 2'd0;
            else if (sel < 8) op = 2'd1;
            else op = 2'($urandom_range(2, 3));
            do_cmd(op, 16'($urandom), 8'($urandom), int'($urandom_range(0, 11)),
                   int'($urandom_range(0, int'(TIMEOUT))), 16'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                bus.eng_done = 2'($urandom);
                step();
                bus.eng_done = 2'b00;
                check_book("rand_idle_done");
            end
        end

        // Reset while waiting; the late done must not land
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = (m_size == int'(DEPTH)) ? 2'd1 : 2'd0;
        bus.cmd_price = 16'h0777;
        bus.cmd_qty   = 8'd7;
        step();
        bus.cmd_valid = 1'b0;
        check_val("mid_start", 32'(bus.eng_start == 2'b00), 32'd0);
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("mid_rst_price", 32'(bus.eng_price), 32'd0);
        check_book("mid_rst");
        #1 rst_n = 1'b1;
        step();
        bus.eng_done       = 2'b11;
        bus.eng_best_price = 16'hCAFE;
        step();
        bus.eng_done = 2'b00;
        step();
        check_val("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check_book("post_rst");
        do_cmd(2'd0, 16'h0042, 8'd9, 2, 0, 16'h0042);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end
endmodule
